spi_frame_tx: RTL and testbench

- SPI master serializer sitting directly downstream of the SPI command generator.
- Consumes the generator's ctrlen/addr/sdata triple and shifts one 24-bit write frame per request to the ADC configuration port (SPI mode 0, MSB first).
- Provides busy/done status back to the control/register side.
- Holds a one-entry pending buffer so a request arriving mid-frame is not lost.

---
 rtl/spi_frame_tx_if.sv | 38 +++
 rtl/spi_frame_tx.sv | 180 ++++++++++++++++++
 tb/tb_spi_frame_tx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_tx_if.sv
// Bundle between the SPI command generator, the serializer and the ADC config port.
// slave  : serializer view (request in, SPI pins and status out).
// master : generator / ADC-side view, the mirror of slave.
// Build option: SPI_READBACK_EN adds rdata[15:0] and rvalid.
interface spi_frame_tx_if;
  logic        ctrlen;
  logic [3:0]  addr;
  logic [15:0] sdata;
  logic        spi_csn;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        busy;
  logic        done;
  logic        ovr;
`ifdef SPI_READBACK_EN
  logic [15:0] rdata;
  logic        rvalid;

  modport slave (
    input  ctrlen, addr, sdata, spi_miso,
    output spi_csn, spi_sclk, spi_mosi, busy, done, ovr, rdata, rvalid
  );
  modport master (
    output ctrlen, addr, sdata, spi_miso,
    input  spi_csn, spi_sclk, spi_mosi, busy, done, ovr, rdata, rvalid
  );
`else
  modport slave (
    input  ctrlen, addr, sdata, spi_miso,
    output spi_csn, spi_sclk, spi_mosi, busy, done, ovr
  );
  modport master (
    output ctrlen, addr, sdata, spi_miso,
    input  spi_csn, spi_sclk, spi_mosi, busy, done, ovr
  );
`endif
endinterface

// File: rtl/spi_frame_tx.sv
// SPI master serializer: one 24-bit write frame {0, 000, addr, sdata} per ctrlen
// rising edge, SPI mode 0, MSB first, with a one-entry pending buffer.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - spi_frame_tx_if.slave: ctrlen/addr/sdata request, spi_csn/spi_sclk/
//          spi_mosi/spi_miso pins, busy/done/ovr status (+ rdata/rvalid)
// Parameters: DIV (clk cycles per SCLK half, 1..255), GAP_HALVES (CS-high
// half-periods between frames, >= 1).
// Build option: SPI_READBACK_EN captures MISO for frame bits 15..0 into rdata.
module spi_frame_tx #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned GAP_HALVES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_frame_tx_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  localparam logic [7:0] HalfLast = 8'(DIV - 1);
  localparam logic [4:0] GapLast  = 5'(GAP_HALVES - 1);
  localparam logic [4:0] LastBit  = 5'd23;

  state_e      state_q;
  logic        ctrlen_q;
  logic [7:0]  half_q;
  logic [4:0]  bit_q;   // bit index in SHIFT, half-period index in GAP
  logic [23:0] shift_q;
  logic        pend_valid_q;
  logic [3:0]  pend_addr_q;
  logic [15:0] pend_data_q;
  logic        csn_q, sclk_q, mosi_q, busy_q, done_q, ovr_q;
`ifdef SPI_READBACK_EN
  logic [15:0] rx_q;
  logic [15:0] rdata_q;
  logic        rvalid_q;
`endif

  logic        req;
  logic        half_last;
  logic        gap_end;
  logic        start;
  logic [23:0] start_word;

  always_comb begin
    req        = bus.ctrlen & ~ctrlen_q;
    half_last  = (half_q == HalfLast);
    gap_end    = (state_q == StGap) && half_last && (bit_q == GapLast);
    // A fresh request always wins the slot over an older pending entry.
    start      = (req | pend_valid_q) & ((state_q == StIdle) | gap_end);
    start_word = req ? {4'b0000, bus.addr, bus.sdata} : {4'b0000, pend_addr_q, pend_data_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ctrlen_q     <= 1'b1;  // a level already high at release is not a request
      half_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      csn_q        <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
`ifdef SPI_READBACK_EN
      rx_q         <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
`endif
    end else begin
      ctrlen_q <= bus.ctrlen;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef SPI_READBACK_EN
      rvalid_q <= 1'b0;
`endif
      // Request that cannot start now is parked; last one wins.
      if (req && !start) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= bus.addr;
        pend_data_q  <= bus.sdata;
        if (pend_valid_q) ovr_q <= 1'b1;
      end

      if (start) begin
        if (req && pend_valid_q) ovr_q <= 1'b1;
        pend_valid_q <= 1'b0;
        shift_q      <= start_word;
        mosi_q       <= start_word[23];
        csn_q        <= 1'b0;
        sclk_q       <= 1'b0;
        busy_q       <= 1'b1;
        half_q       <= '0;
        bit_q        <= '0;
        state_q      <= StSetup;
`ifdef SPI_READBACK_EN
        rx_q         <= '0;
`endif
      end else begin
        if (state_q != StIdle) half_q <= half_last ? 8'd0 : half_q + 8'd1;

        unique case (state_q)
          StIdle: begin
          end
          StSetup: begin
            if (half_last) begin
              sclk_q  <= 1'b1;
              state_q <= StShift;
            end
          end
          StShift: begin
            if (half_last) begin
              if (sclk_q) begin
                // Falling transition: present the next bit unless the last one is out.
                sclk_q <= 1'b0;
                if (bit_q != LastBit) begin
                  shift_q <= {shift_q[22:0], 1'b0};
                  mosi_q  <= shift_q[22];
                end
              end else if (bit_q == LastBit) begin
                state_q <= StHold;
              end else begin
                sclk_q <= 1'b1;
                bit_q  <= bit_q + 5'd1;
`ifdef SPI_READBACK_EN
                // Rising into frame bit bit_q+1; only bits 8..23 carry read data.
                if (bit_q >= 5'd7) rx_q <= {rx_q[14:0], bus.spi_miso};
`endif
              end
            end
          end
          StHold: begin
            if (half_last) begin
              csn_q   <= 1'b1;
              done_q  <= 1'b1;
              mosi_q  <= 1'b0;
              bit_q   <= '0;
              state_q <= StGap;
`ifdef SPI_READBACK_EN
              rdata_q  <= rx_q;
              rvalid_q <= 1'b1;
`endif
            end
          end
          StGap: begin
            if (half_last) begin
              if (bit_q == GapLast) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                bit_q   <= '0;
              end else begin
                bit_q <= bit_q + 5'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.spi_csn  = csn_q;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ovr      = ovr_q;
`ifdef SPI_READBACK_EN
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
`endif

endmodule

// File: tb/tb_spi_frame_tx.sv
// Directed bench for spi_frame_tx: table of single frames at DIV=4, then hand
// sequences for reset-level ctrlen, pending, overwrite, gap-end collision,
// reset abort and a DIV=1 frame length.
module tb_spi_frame_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_frame_tx_if bus ();
  spi_frame_tx_if bus1 ();

  spi_frame_tx #(.DIV(4), .GAP_HALVES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  spi_frame_tx #(.DIV(1), .GAP_HALVES(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: records each completed frame (sampled at negedge).
  logic        prev_sclk = 1'b0;
  logic        prev_csn  = 1'b1;
  logic [23:0] mon_word  = '0;
  int          mon_bits  = 0;
  int          mon_low   = 0;
  int          rc        = 0;
  logic [23:0] frames[$];
  int          lens[$];
  int          nbits[$];
  int          done_cnt  = 0;
  int          ovr_cnt   = 0;
  int          done_mis  = 0;
  logic [15:0] miso_pat  = 16'h5AA5;

  initial forever begin
    @(negedge clk);
    if (prev_csn && bus.spi_csn === 1'b0) begin
      mon_word = '0;
      mon_bits = 0;
      mon_low  = 0;
      rc       = 0;
    end
    if (bus.spi_csn === 1'b0) mon_low++;
    if (!prev_sclk && bus.spi_sclk === 1'b1) begin
      mon_word = {mon_word[22:0], bus.spi_mosi};
      mon_bits++;
      rc++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      frames.push_back(mon_word);
      lens.push_back(mon_low);
      nbits.push_back(mon_bits);
      if (!(!prev_csn && bus.spi_csn === 1'b1)) done_mis++;
    end
    if (bus.ovr === 1'b1) ovr_cnt++;
    prev_sclk = bus.spi_sclk;
    prev_csn  = bus.spi_csn;
  end

  // MISO model: frame bit k (k = rising edges already seen) carries pattern bit 23-k.
  assign bus.spi_miso  = (rc >= 8 && rc < 24) ? miso_pat[4'(23 - rc)] : 1'b0;
  assign bus1.spi_miso = 1'b0;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [3:0] a, input logic [15:0] d);
    bus.addr   = a;
    bus.sdata  = d;
    bus.ctrlen = 1'b1;
    step(1);
    bus.ctrlen = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < bound) begin
      step(1);
      n++;
    end
    if (n >= bound) check("done timeout", 32'(n), 32'(bound - 1));
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (bus.busy !== 1'b0 && n < bound) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_frames(input int target, input int bound);
    int n = 0;
    while (frames.size() < target && n < bound) begin
      step(1);
      n++;
    end
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
    logic [23:0] word;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int nf, n, g, lo, ov, dc;

    vecs[0] = '{a: 4'h5, d: 16'hA3C1, word: 24'h05A3C1};
    vecs[1] = '{a: 4'hF, d: 16'hFFFF, word: 24'h0FFFFF};
    vecs[2] = '{a: 4'h0, d: 16'h0000, word: 24'h000000};
    vecs[3] = '{a: 4'hA, d: 16'h5555, word: 24'h0A5555};

    rst         = 1'b1;
    bus.ctrlen  = 1'b0;
    bus.addr    = '0;
    bus.sdata   = '0;
    bus1.ctrlen = 1'b0;
    bus1.addr   = '0;
    bus1.sdata  = '0;
    step(2);
    check("reset outputs", {bus.spi_csn, bus.spi_sclk, bus.spi_mosi, bus.busy, bus.done, bus.ovr},
          6'b100000);
`ifdef SPI_READBACK_EN
    check("reset rdata", bus.rdata, 16'h0000);
`endif
    rst = 1'b0;
    step(2);

    // Table of single frames.
    for (int i = 0; i < 4; i++) begin
      nf = frames.size();
      request(vecs[i].a, vecs[i].d);
      check("cs latency", bus.spi_csn, 1'b0);
      wait_done(400, n);
`ifdef SPI_READBACK_EN
      check("rdata", bus.rdata, 16'h5AA5);
      check("rvalid with done", bus.rvalid, 1'b1);
`endif
      wait_idle(20, g);
      check("busy low after gap", 32'(g), 32'd8);
      check("frame count", 32'(frames.size()), 32'(nf + 1));
      check("frame word", frames[nf], vecs[i].word);
      check("cs low cycles", 32'(lens[nf]), 32'd200);
      check("sclk rises", 32'(nbits[nf]), 32'd24);
      step(3);
    end

    // ctrlen held high through reset release is not a request.
    nf = frames.size();
    bus.ctrlen = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(20);
    check("no frame from held ctrlen", {31'b0, bus.busy}, 32'd0);
    check("held ctrlen frame count", 32'(frames.size()), 32'(nf));
    bus.ctrlen = 1'b0;
    step(1);
    request(4'h3, 16'hC0DE);
    wait_done(400, n);
    wait_idle(20, g);
    check("later edge one frame", 32'(frames.size()), 32'(nf + 1));
    check("later edge word", frames[nf], 24'h03C0DE);
    step(3);

    // Pending request mid-frame: back-to-back frames, busy never drops.
    nf = frames.size();
    ov = ovr_cnt;
    lo = 0;
    request(4'h2, 16'h1234);
    step(40);
    request(4'h1, 16'h0001);
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      if (bus.busy !== 1'b1) lo++;
      step(1);
      n++;
    end
    g = 0;
    while (bus.spi_csn !== 1'b0 && g < 20) begin
      if (bus.busy !== 1'b1) lo++;
      step(1);
      g++;
    end
    check("pending cs high cycles", 32'(g), 32'd8);
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      if (bus.busy !== 1'b1) lo++;
      step(1);
      n++;
    end
    check("busy continuous", 32'(lo), 32'd0);
    wait_idle(20, g);
    check("pending frame count", 32'(frames.size()), 32'(nf + 2));
    check("pending first word", frames[nf], 24'h021234);
    check("pending second word", frames[nf + 1], 24'h010001);
    check("pending no ovr", 32'(ovr_cnt - ov), 32'd0);
    step(3);

    // Overwrite: third request replaces the second.
    nf = frames.size();
    ov = ovr_cnt;
    request(4'h3, 16'h0303);
    step(20);
    request(4'h4, 16'h4444);
    step(20);
    request(4'h6, 16'h6666);
    wait_frames(nf + 2, 1200);
    wait_idle(20, g);
    step(20);
    check("overwrite ovr pulses", 32'(ovr_cnt - ov), 32'd1);
    check("overwrite frame count", 32'(frames.size()), 32'(nf + 2));
    check("overwrite first word", frames[nf], 24'h030303);
    check("overwrite second word", frames[nf + 1], 24'h066666);
    step(3);

    // Request in the last gap cycle with a pending entry: new one wins.
    nf = frames.size();
    ov = ovr_cnt;
    request(4'h7, 16'h7777);
    step(20);
    request(4'h8, 16'h8888);
    wait_done(400, n);
    step(7);
    bus.addr   = 4'h9;
    bus.sdata  = 16'h9999;
    bus.ctrlen = 1'b1;
    step(1);
    bus.ctrlen = 1'b0;
    check("gap-end ovr pulse", bus.ovr, 1'b1);
    check("gap-end restart", bus.spi_csn, 1'b0);
    wait_frames(nf + 2, 600);
    wait_idle(20, g);
    step(20);
    check("gap-end frame count", 32'(frames.size()), 32'(nf + 2));
    check("gap-end second word", frames[nf + 1], 24'h099999);
    check("gap-end ovr count", 32'(ovr_cnt - ov), 32'd1);
    step(3);

    // Reset mid-frame at bit 10.
    nf = frames.size();
    request(4'hB, 16'hBEEF);
    n = 0;
    while (mon_bits < 10 && n < 300) begin
      step(1);
      n++;
    end
    check("reached bit 10", {31'b0, mon_bits >= 10}, 32'd1);
    dc = done_cnt;
    rst = 1'b1;
    step(1);
    check("abort outputs", {bus.spi_csn, bus.spi_sclk, bus.spi_mosi, bus.busy}, 4'b1000);
    rst = 1'b0;
    step(30);
    check("abort no done", 32'(done_cnt - dc), 32'd0);
    check("abort no frame", 32'(frames.size()), 32'(nf));
`ifdef SPI_READBACK_EN
    check("abort rdata", bus.rdata, 16'h0000);
`endif

    // DIV=1 frame length.
    bus1.addr   = 4'h1;
    bus1.sdata  = 16'h00FF;
    bus1.ctrlen = 1'b1;
    step(1);
    bus1.ctrlen = 1'b0;
    check("div1 cs latency", bus1.spi_csn, 1'b0);
    lo = 0;
    n  = 0;
    while (bus1.done !== 1'b1 && n < 200) begin
      if (bus1.spi_csn === 1'b0) lo++;
      step(1);
      n++;
    end
    check("div1 cs low cycles", 32'(lo), 32'd50);

    check("done with cs rise", 32'(done_mis), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
